// File: rtl/elapsed_timer_if.sv
// rtl/elapsed_timer_if.sv - control/status bundle between the elapsed timer and its user
interface elapsed_timer_if #(
  parameter int WIDTH = 32
);

  // Controls, driven by the user of the timer
  logic             i_run;
  logic             i_clear;
  logic [WIDTH-1:0] i_threshold;

  // Status, driven by the timer
  logic [WIDTH-1:0] o_elapsed;
  logic             o_sec_tick;
  logic             o_reached;
  logic             o_saturated;

  modport master (
    output i_run,
    output i_clear,
    output i_threshold,
    input  o_elapsed,
    input  o_sec_tick,
    input  o_reached,
    input  o_saturated
  );

  modport slave (
    input  i_run,
    input  i_clear,
    input  i_threshold,
    output o_elapsed,
    output o_sec_tick,
    output o_reached,
    output o_saturated
  );

endinterface

// File: rtl/elapsed_timer.sv
// rtl/elapsed_timer.sv - saturating count-up seconds timer with sticky threshold flag
module elapsed_timer #(
  parameter int WIDTH         = 32,
  parameter int TICKS_PER_SEC = 100_000_000
) (
  input  logic          clk,
  input  logic          rst,
  elapsed_timer_if.slave bus
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] P_TERM = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t           r_state;
  logic [PW-1:0]    r_prescaler;
  logic [WIDTH-1:0] r_elapsed;
  logic             r_sec_tick;
  logic             r_reached;
  logic             r_saturated;
  logic             r_clear_d;

  logic             w_clear_edge;
  logic             w_at_term;
  logic             w_at_max;
  logic             w_reach_hit;

  assign w_clear_edge = bus.i_clear & ~r_clear_d;
  assign w_at_term    = (r_prescaler == P_TERM);
  assign w_at_max     = &r_elapsed;
  // A zero threshold disables the reminder entirely
  assign w_reach_hit  = (bus.i_threshold != '0) && (r_elapsed >= bus.i_threshold);

  assign bus.o_elapsed   = r_elapsed;
  assign bus.o_sec_tick  = r_sec_tick;
  assign bus.o_reached   = r_reached;
  assign bus.o_saturated = r_saturated;

  // Delayed copy of clear so only its rising edge acts; a held clear lets counting resume
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clear_d <= 1'b0;
    end else begin
      r_clear_d <= bus.i_clear;
    end
  end

  // Run/hold state machine with prescaler, seconds counter and sticky flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_prescaler <= '0;
      r_elapsed   <= '0;
      r_sec_tick  <= 1'b0;
      r_reached   <= 1'b0;
      r_saturated <= 1'b0;
    end else begin
      r_sec_tick <= 1'b0;
      if (w_clear_edge) begin
        // Clear beats everything, including a coincident terminal count
        r_state     <= S_IDLE;
        r_prescaler <= '0;
        r_elapsed   <= '0;
        r_reached   <= 1'b0;
        r_saturated <= 1'b0;
      end else begin
        r_reached <= r_reached | w_reach_hit;
        case (r_state)
          S_IDLE: begin
            if (bus.i_run) begin
              r_state <= S_RUN;
            end
          end
          S_RUN: begin
            // The cycle in which run drops still counts; the pause starts after it
            if (w_at_term) begin
              r_prescaler <= '0;
              r_sec_tick  <= 1'b1;
              if (w_at_max) begin
                r_saturated <= 1'b1;
              end else begin
                r_elapsed <= r_elapsed + 1'b1;
              end
            end else begin
              r_prescaler <= r_prescaler + 1'b1;
            end
            if (!bus.i_run) begin
              r_state <= S_HOLD;
            end
          end
          S_HOLD: begin
            // Prescaler is left untouched so a partial second survives the pause
            if (bus.i_run) begin
              r_state <= S_RUN;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_elapsed_timer.sv
// tb/tb_elapsed_timer.sv - directed self-checking bench for elapsed_timer
module tb_elapsed_timer;

  logic clk;
  logic rst;

  int n_checks;
  int n_errors;

  elapsed_timer_if #(.WIDTH(8)) bus8 ();
  elapsed_timer_if #(.WIDTH(4)) bus4 ();

  elapsed_timer #(.WIDTH(8), .TICKS_PER_SEC(4)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  elapsed_timer #(.WIDTH(4), .TICKS_PER_SEC(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       run;
    logic       clr;
    logic [7:0] thr;
    logic [7:0] e;
    logic       t;
    logic       r;
    logic       s;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] e, input logic t,
                        input logic r, input logic s);
    check({name, ".elapsed"},   32'(bus8.o_elapsed),   32'(e));
    check({name, ".sec_tick"},  32'(bus8.o_sec_tick),  32'(t));
    check({name, ".reached"},   32'(bus8.o_reached),   32'(r));
    check({name, ".saturated"}, 32'(bus8.o_saturated), 32'(s));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus8.i_run = 1'b0; bus8.i_clear = 1'b0; bus8.i_threshold = '0;
    bus4.i_run = 1'b0; bus4.i_clear = 1'b0; bus4.i_threshold = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    // run, clear, threshold, elapsed, tick, reached, saturated (after each edge)
    vecs[0]  = '{1'b1, 1'b0, 8'd2, 8'd0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 8'd2, 8'd0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 8'd2, 8'd0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 8'd2, 8'd0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 8'd2, 8'd1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 8'd2, 8'd1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 8'd2, 8'd1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 8'd2, 8'd1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 8'd2, 8'd2, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 8'd2, 8'd2, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 8'd2, 8'd2, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 8'd2, 8'd2, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 8'd2, 8'd3, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 8'd2, 8'd3, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 8'd9, 8'd3, 1'b0, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 8'd9, 8'd3, 1'b0, 1'b1, 1'b0};

    rst = 1'b1;
    bus8.i_run = 1'b0; bus8.i_clear = 1'b0; bus8.i_threshold = '0;
    bus4.i_run = 1'b0; bus4.i_clear = 1'b0; bus4.i_threshold = '0;
    #1;
    check8("reset", 8'd0, 1'b0, 1'b0, 1'b0);
    check("reset.w4.elapsed", 32'(bus4.o_elapsed), 32'd0);
    check("reset.w4.saturated", 32'(bus4.o_saturated), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Counting, tick spacing and threshold behaviour from the vector table
    for (int i = 0; i < 16; i++) begin
      bus8.i_run       = vecs[i].run;
      bus8.i_clear     = vecs[i].clr;
      bus8.i_threshold = vecs[i].thr;
      @(negedge clk);
      check8($sformatf("vec%0d", i), vecs[i].e, vecs[i].t, vecs[i].r, vecs[i].s);
    end

    // Pause keeps the partial second: held prescaler 2, resume needs 1+2 edges
    do_reset();
    bus8.i_run = 1'b1;
    repeat (6) @(negedge clk);
    check("pause.before", 32'(bus8.o_elapsed), 32'd1);
    bus8.i_run = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("pause.hold_elapsed", 32'(bus8.o_elapsed), 32'd1);
      check("pause.hold_tick", 32'(bus8.o_sec_tick), 32'd0);
    end
    bus8.i_run = 1'b1;
    @(negedge clk);
    check8("pause.resume0", 8'd1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check8("pause.resume1", 8'd1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check8("pause.resume2", 8'd2, 1'b1, 1'b0, 1'b0);

    // Clear edge landing on a terminal count, then restart with clear held
    do_reset();
    bus8.i_threshold = 8'd3;
    bus8.i_run = 1'b1;
    repeat (16) @(negedge clk);
    check8("clr.before", 8'd3, 1'b0, 1'b1, 1'b0);
    bus8.i_clear = 1'b1;
    @(negedge clk);
    check8("clr.edge", 8'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check8($sformatf("clr.restart%0d", k), (k == 5) ? 8'd1 : 8'd0,
             (k == 5), 1'b0, 1'b0);
    end
    bus8.i_clear = 1'b0;

    // Asynchronous reset mid-count (elapsed=5, prescaler=2)
    do_reset();
    bus8.i_threshold = 8'd4;
    bus8.i_run = 1'b1;
    repeat (23) @(negedge clk);
    check8("arst.before", 8'd5, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    check8("arst.async", 8'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus8.i_run = 1'b0;
    bus8.i_threshold = 8'd0;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("arst.idle_elapsed", 32'(bus8.o_elapsed), 32'd0);
    end
    bus8.i_run = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      check("arst.first_tick", 32'(bus8.o_sec_tick), 32'(k == 4));
      check("arst.first_sec", 32'(bus8.o_elapsed), 32'(k == 4));
    end
    bus8.i_run = 1'b0;

    // WIDTH=4 saturation: holds at 15, flags saturated, ticks continue
    do_reset();
    bus4.i_run = 1'b1;
    for (int k = 0; k <= 68; k++) begin
      logic [3:0] exp_e;
      @(negedge clk);
      exp_e = ((k / 4) > 15) ? 4'd15 : 4'(k / 4);
      check($sformatf("sat.elapsed%0d", k), 32'(bus4.o_elapsed), 32'(exp_e));
      check($sformatf("sat.tick%0d", k), 32'(bus4.o_sec_tick),
            32'((k >= 4) && (k % 4 == 0)));
      check($sformatf("sat.flag%0d", k), 32'(bus4.o_saturated), 32'(k >= 64));
      check($sformatf("sat.reached%0d", k), 32'(bus4.o_reached), 32'd0);
    end
    bus4.i_run = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
